// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared types, default widths and byte helpers for regbus_master
package regbus_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Helpers operate on the widest supported bus; callers size-cast in and out.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STRB_NONE    = 2'd0,
    STRB_ALL     = 2'd1,
    STRB_PARTIAL = 2'd2
  } strb_class_t;

  // Strobed bytes come from data, the rest from old.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_DATA_W-1:0] old,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

  // Only the low n strobe bits are meaningful for the actual bus width.
  function automatic strb_class_t strb_classify(
    input logic [MAX_STRB_W-1:0] strb,
    input int                    n
  );
    logic [MAX_STRB_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    if ((strb & mask) == '0) return STRB_NONE;
    if ((strb & mask) == mask) return STRB_ALL;
    return STRB_PARTIAL;
  endfunction

endpackage

// File: rtl/regbus_master.sv
// rtl/regbus_master.sv - one-command-at-a-time register bus initiator with RMW and read timeout
module regbus_master
  import regbus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   addr,
  output logic                chip_select,
  output logic                write_en,
  output logic                read_en,
  output logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                data_valid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                rmw_q, rmw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   write_data_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_err_d;

  logic                accept;
  strb_class_t         cmd_class;
  logic                timed_out;
  logic [DATA_W-1:0]   merged;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_class = strb_classify(MAX_STRB_W'(cmd_wstrb), STRB_W);
  assign timed_out = !data_valid && (cnt_q == CNT_LAST);
  assign merged    = DATA_W'(byte_merge(MAX_DATA_W'(wdata_q), MAX_DATA_W'(read_data),
                                        MAX_STRB_W'(wstrb_q)));

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: route by command type and strobe class, leave RD on data or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_write) state_d = RD;
          else begin
            case (cmd_class)
              STRB_ALL:  state_d = WR;
              STRB_NONE: state_d = RESP;
              default:   state_d = RD;
            endcase
          end
        end
      end
      RD: begin
        if (data_valid)     state_d = rmw_q ? WR : RESP;
        else if (timed_out) state_d = RESP;
      end
      WR:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch command, capture/merge read data, run wait counter.
  always_comb begin
    rmw_d        = rmw_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    addr_d       = addr;
    write_data_d = write_data;
    rsp_rdata_d  = rsp_rdata;
    rsp_err_d    = rsp_err;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rmw_d       = cmd_write && (cmd_class == STRB_PARTIAL);
          cnt_d       = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (cmd_write && (cmd_class == STRB_ALL)) write_data_d = cmd_wdata;
        end
      end
      RD: begin
        if (data_valid) begin
          if (rmw_q) begin
            write_data_d = merged;
            rsp_rdata_d  = merged;
          end else begin
            rsp_rdata_d  = read_data;
          end
        end else if (timed_out) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; strobes follow the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      addr        <= '0;
      write_data  <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_valid   <= 1'b0;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      chip_select <= 1'b0;
    end else begin
      rmw_q       <= rmw_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      addr        <= addr_d;
      write_data  <= write_data_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_valid   <= (state_d == RESP);
      read_en     <= (state_d == RD);
      write_en    <= (state_d == WR);
      chip_select <= (state_d == RD) || (state_d == WR);
    end
  end

endmodule
